// File: rtl/mul_seq_if.sv
// Operand/request and write-back bus of the sequential multiplier.
// The master side is the CPU/regfile, the slave side is mul_seq.
interface mul_seq_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    dest;
  logic             signed_op;
  logic             busy;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] hi;
  logic             zf;
  logic             zf_load;

  modport master (
    output start, a, b, dest, signed_op,
    input  busy, we, wa, wd, hi, zf, zf_load
  );

  modport slave (
    input  start, a, b, dest, signed_op,
    output busy, we, wa, wd, hi, zf, zf_load
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential WIDTHxWIDTH shift-add multiplier feeding the regfile write port and zero flag.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul_seq #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input logic      clk,
  input logic      reset,
  mul_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             neg_q, neg_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic             busy_q, busy_d;
  logic             we_q, we_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zf_q, zf_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [CW-1:0]      cnt_run;
  logic [2*WIDTH-1:0] fin;
  logic [2*WIDTH-1:0] fin_p;
  logic [2*WIDTH-1:0] wb_p;
  logic               go_wb;
`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0]   rem_mask;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    dest_d  = dest_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    hi_d    = hi_q;
    zf_d    = zf_q;
    go_wb   = 1'b0;
    fin     = '0;

    mag_a   = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b   = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    // {carry, acc, multiplier} >> 1: multiplier LSB falls off the bottom
    shifted = {sum, mplr_q[WIDTH-1:1]};
    cnt_run = cnt_q - CW'(1);
    wb_p    = neg_q ? -{acc_q, mplr_q} : {acc_q, mplr_q};
`ifdef MUL_EARLY_EXIT_EN
    rem_mask = (WIDTH'(1) << cnt_run) - WIDTH'(1);
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = mag_a;
          mplr_d  = mag_b;
          neg_d   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          dest_d  = bus.dest;
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef MUL_EARLY_EXIT_EN
          if (mag_b == '0) begin
            acc_d  = '0;
            mplr_d = '0;
            go_wb  = 1'b1;
            fin    = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d  = shifted[2*WIDTH-1:WIDTH];
        mplr_d = shifted[WIDTH-1:0];
        cnt_d  = cnt_run;
        if (cnt_run == '0) begin
          go_wb = 1'b1;
          fin   = shifted;
        end
`ifdef MUL_EARLY_EXIT_EN
        // Remaining multiplier bits sit in the low cnt_run bits; if all zero,
        // shift the partial product down into its final position now.
        else if ((shifted[WIDTH-1:0] & rem_mask) == '0) begin
          go_wb  = 1'b1;
          fin    = shifted >> cnt_run;
          acc_d  = fin[2*WIDTH-1:WIDTH];
          mplr_d = fin[WIDTH-1:0];
        end
`endif
      end
      WB: begin
        hi_d    = wb_p[2*WIDTH-1:WIDTH];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fin_p = neg_q ? -fin : fin;
    if (go_wb) begin
      state_d = WB;
      we_d    = 1'b1;
      wa_d    = (state_q == IDLE) ? bus.dest : dest_q;
      wd_d    = fin_p[WIDTH-1:0];
      zf_d    = (fin_p == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      hi_q    <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      dest_q  <= dest_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      hi_q    <= hi_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.we      = we_q;
  assign bus.wa      = wa_q;
  assign bus.wd      = wd_q;
  assign bus.hi      = hi_q;
  assign bus.zf      = zf_q;
  assign bus.zf_load = we_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed operands with hand-computed products,
// write-back cycle, hi update, busy window, ignored start and reset abort.
module tb_mul_seq;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  mul_seq #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] hi;
    logic        zf;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        hi_chk = 1'b0;
  logic [15:0] hi_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles from the start edge to the cycle in which we is high.
  function automatic int unsigned lat_of(input logic [15:0] b, input logic sgn);
`ifdef MUL_EARLY_EXIT_EN
    logic [15:0] mag;
    mag = (sgn && b[15]) ? -b : b;
    if (mag == 16'h0) return 1;
    for (int i = 15; i >= 0; i--)
      if (mag[i]) return i + 2;
    return 1;
`else
    if (sgn) return 17;
    return 17 + 0 * b;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (hi_chk) begin
        chk("hi", bus.hi, hi_exp);
        hi_chk = 1'b0;
      end
      if (bus.we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: got we=1 wa=%0h wd=%0h expected no write", bus.wa, bus.wd);
        end else begin
          mon_e = sb.pop_front();
          chk("wa", bus.wa, mon_e.wa);
          chk("wd", bus.wd, mon_e.wd);
          chk("zf", bus.zf, mon_e.zf);
          chk("zf_load", bus.zf_load, 1);
          chk("we_cycle", cyc, mon_e.cyc);
          hi_exp = mon_e.hi;
          hi_chk = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] d,
                       input logic sgn, input logic [31:0] p, input bit push);
    exp_t e;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.dest = d;
    bus.signed_op = sgn;
    bus.start = 1'b1;
    if (push) begin
      e.wa  = d;
      e.wd  = p[15:0];
      e.hi  = p[31:16];
      e.zf  = (p == 32'h0);
      e.cyc = cyc + lat_of(b, sgn);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    bus.dest = 4'hF;
    bus.signed_op = ~sgn;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !hi_chk) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got %0d pending writes expected 0", sb.size());
    sb.delete();
    hi_chk = 1'b0;
  endtask

  initial begin
    int unsigned lat;
    int unsigned ign;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.dest = '0;
    bus.signed_op = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_wa", bus.wa, 0);
    chk("rst_wd", bus.wd, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_zf", bus.zf, 0);
    chk("rst_zf_load", bus.zf_load, 0);
    reset = 1'b0;

    issue(16'hFFFF, 16'hFFFF, 4'd5, 1'b0, 32'hFFFE_0001, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), bus.busy, (k <= 17) ? 1 : 0);
    end
    wait_idle();

    issue(16'hFFFD, 16'h0005, 4'd3, 1'b1, 32'hFFFF_FFF1, 1'b1);
    wait_idle();

`ifdef MUL_EARLY_EXIT_EN
    issue(16'h0007, 16'h7007, 4'd6, 1'b0, 32'h0, 1'b0);
`else
    issue(16'h0007, 16'h0007, 4'd6, 1'b0, 32'h0, 1'b0);
`endif
    repeat (7) @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_we", bus.we, 0);
    chk("abort_wd", bus.wd, 0);
    chk("abort_hi", bus.hi, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(16'h8000, 16'h8000, 4'd7, 1'b1, 32'h4000_0000, 1'b1);
    wait_idle();
    issue(16'h0100, 16'h0100, 4'd1, 1'b0, 32'h0001_0000, 1'b1);
    wait_idle();
    issue(16'h1234, 16'h0000, 4'd0, 1'b0, 32'h0, 1'b1);
    wait_idle();
    issue(16'h0007, 16'h0001, 4'd9, 1'b0, 32'h7, 1'b1);
    wait_idle();

    lat = lat_of(16'h0004, 1'b0);
`ifdef MUL_EARLY_EXIT_EN
    ign = 2;
`else
    ign = 5;
`endif
    issue(16'h0003, 16'h0004, 4'd2, 1'b0, 32'hC, 1'b1);
    repeat (ign) @(negedge clk);
    bus.a = 16'h0009;
    bus.b = 16'h0009;
    bus.dest = 4'd3;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (lat - ign) @(negedge clk);
    issue(16'h0005, 16'h0006, 4'd4, 1'b0, 32'h1E, 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential 16x16 shift-add multiplier for the 16-bit monocycle CPU datapath.
- Sits directly upstream of the register file write port: it consumes regfile read data (operands), produces the write-back triple (we, wa, wd), and feeds the zero-flag flip-flop (d, carga).
- Stalls the CPU via busy while the multiply iterates. Holds the upper product half in an internal HI register.

Parameters:
WIDTH, 16, operand and result-half width
AW, 4, register-address width (16 registers)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  multiplicand (regfile rd1)
b  in  WIDTH  multiplier (regfile rd2)
dest  in  AW  destination register address
signed_op  in  1  1 = two's-complement operands, 0 = unsigned
busy  out  1  high while in RUN or WB; CPU holds PC while high
we  out  1  one-cycle write strobe to regfile we3
wa  out  AW  write address to regfile wa3
wd  out  WIDTH  low product half to regfile wd3
hi  out  WIDTH  upper product half of last completed multiply
zf  out  1  1 when full 2*WIDTH product == 0; valid while we=1
zf_load  out  1  equals we; drives flag flip-flop load enable

Behaviour:
- Reset (async, any state): state=IDLE; busy, we, zf, zf_load = 0; wa, wd, hi = 0; counter and accumulator cleared. An in-flight multiply is aborted with no write.
- FSM states: IDLE, RUN, WB.
- IDLE:
  - On start=1, latch |a|, |b| (magnitudes when signed_op=1, raw values otherwise).
  - Latch the result sign: a[15]^b[15] when signed, else 0.
  - Latch dest; counter=WIDTH; accumulator=0; go to RUN.
- RUN, one iteration per cycle:
  - If multiplier LSB=1, add multiplicand to accumulator upper half with a WIDTH+1-bit carry.
  - Shift {carry, acc, multiplier} right 1; counter--.
  - When counter reaches 0 after this iteration, go to WB.
- WB, one cycle:
  - Product P = latched sign ? -acc : acc, 2*WIDTH bits.
  - we=1, zf_load=1, wa=dest, wd=P[15:0], zf=(P==0).
  - hi register loads P[31:16] at the WB→IDLE edge.
  - Next state is IDLE.
- Latency: start sampled at edge 0 → RUN for cycles 1..16 → we high in cycle 17 → regfile written at edge 18. busy high in cycles 1..17.
- start while busy: ignored, no queueing. start is accepted again in the cycle after WB (back-to-back issue is allowed).
- Magnitude of -32768 is 32768, which fits unsigned in WIDTH bits. No overflow is possible.
- dest=0: the write is still issued; the regfile masks reads of register 0.
- Operands a, b, dest, signed_op may change after the start edge without affecting the result.
- wa, wd, zf hold their last values outside WB. Only we and zf_load qualify them.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN
- Defined:
  - In RUN, if the shifted multiplier remainder is 0, go to WB immediately. The accumulator is aligned by shifting it right by the remaining counter value in the same cycle.
  - In IDLE, if the magnitude of b is 0, go directly to WB.
  - Latency varies: 1 + (index of highest set bit of |b| + 1) cycles to WB. b=0 gives WB in cycle 1.
- Undefined: fixed 16 RUN cycles; latency always 17 cycles to we.

Test Plan:
- Unsigned a=0xFFFF, b=0xFFFF, dest=5 → we high in cycle 17 only, wa=5, wd=0x0001, zf=0; hi=0xFFFE after the WB edge; busy high cycles 1..17.
- Signed a=0xFFFD(-3), b=0x0005 → wd=0xFFF1, hi=0xFFFF, zf=0. Signed a=0x8000, b=0x8000 → wd=0x0000, hi=0x4000, zf=0.
- Unsigned a=0x0100, b=0x0100 → wd=0x0000, hi=0x0001, zf=0 (full product nonzero). Then a=0x1234, b=0 → wd=0, hi=0, zf=1, zf_load=1.
- Start a=3, b=4. At cycle 5 assert start with a=9, b=9 → ignored; result wd=0x000C in cycle 17, exactly one we pulse. Start in cycle 18 is accepted.
- Start a=7, b=7. Assert reset in cycle 8 → busy, we, wd, hi = 0 immediately, no we pulse. After release, a fresh start completes normally.
- With MUL_EARLY_EXIT_EN: a=7, b=1 → we in cycle 2, wd=7. b=0 → we in cycle 1, zf=1. Without the macro, the same stimuli give we in cycle 17.
